midi_msg_receiver: RTL and testbench

Parametrised MIDI input block. It deserialises the MIDI serial line with mid-bit sampling, false-start rejection and stop-bit checking. It then assembles complete channel-voice messages, including running status, real-time pass-through, optional channel filtering and optional note-on-velocity-0 to note-off conversion. It sits between the board MIDI input pin and note/display logic, and delivers one-cycle message strobes in place of raw bit framing.

---
 rtl/midi_msg_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_midi_msg_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/midi_msg_receiver.sv
// midi_msg_receiver
//   MIDI input block. It deserialises the asynchronous MIDI line using mid-bit
//   sampling, false-start rejection and stop-bit checking. It then assembles
//   channel-voice messages with running status, real-time pass-through,
//   optional channel filtering and optional note-on-velocity-0 to note-off
//   conversion.
//
// Ports
//   clck        system clock, rising edge
//   rst         synchronous reset, active-high
//   midi_data   asynchronous serial line, idle high
//   channel     accepted channel when filtering and omni=0
//   omni        1 = accept every channel
//   byte_valid  1-cycle strobe, correctly framed byte in byte_data
//   byte_data   last received byte, held between strobes
//   msg_valid   1-cycle strobe, complete channel-voice message
//   msg_status  message status byte (0x80..0xEF)
//   msg_data1   first data byte
//   msg_data2   second data byte, 0 for 0xCn/0xDn messages
//   rt_valid    1-cycle strobe, real-time byte (0xF8..0xFF)
//   rt_byte     last real-time byte, held between strobes
//   frame_err   1-cycle strobe, stop bit sampled low
module midi_msg_receiver #(
  parameter int CLKS_PER_BIT        = 128,
  parameter int SYNC_STAGES         = 2,
  parameter bit NOTE_ON_ZERO_AS_OFF = 1'b1,
  parameter bit FILTER_EN           = 1'b1
) (
  input  logic       clck,
  input  logic       rst,
  input  logic       midi_data,
  input  logic [3:0] channel,
  input  logic       omni,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and bit-level receiver
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  bit_state_t             state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: every sequential assignment uses <= so all registers update from
  // the same pre-edge values; a blocking '=' here would make the result
  // depend on statement order.
  always_ff @(posedge clck) begin
    if (rst) begin
      // Synchroniser loads idle-high so releasing reset cannot fake a start.
      sync_q     <= '1;
      s_prev     <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      rt_valid   <= 1'b0;
      rt_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], midi_data};
      s_prev     <= s;
      byte_valid <= 1'b0;
      rt_valid   <= 1'b0;
      frame_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (s_prev && !s) begin
            cnt   <= '0;
            state <= START;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            // A line that is high again at mid-start-bit was only a glitch.
            if (!s) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {s, shreg[7:1]};  // LSB arrives first
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == FULL_M1) begin
            // Return to IDLE at mid-stop-bit so a back-to-back start edge is seen.
            state <= IDLE;
            if (s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
              // Real-time bytes bypass the assembler and appear with byte_valid.
              if (shreg[7:3] == 5'b11111) begin
                rt_valid <= 1'b1;
                rt_byte  <= shreg;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Message assembler
  // ---------------------------------------------------------------------------
  logic [7:0] run_status;  // bit 7 set = running status valid
  logic       have_d1;
  logic [6:0] data1_q;

  logic       need_one;
  logic       chan_ok;
  logic       conv;
  logic [6:0] comp_d1;
  logic [6:0] comp_d2;
  logic [7:0] comp_status;

  always_comb begin
    need_one    = (run_status[7:5] == 3'b110);  // 0xCn / 0xDn carry one data byte
    comp_d1     = need_one ? byte_data[6:0] : data1_q;
    comp_d2     = need_one ? 7'd0 : byte_data[6:0];
    chan_ok     = !FILTER_EN || omni || (run_status[3:0] == channel);
    conv        = NOTE_ON_ZERO_AS_OFF && (run_status[7:4] == 4'h9) && (comp_d2 == 7'd0);
    comp_status = conv ? {4'h8, run_status[3:0]} : run_status;
  end

  always_ff @(posedge clck) begin
    if (rst) begin
      run_status <= '0;
      have_d1    <= 1'b0;
      data1_q    <= '0;
      msg_valid  <= 1'b0;
      msg_status <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
    end else begin
      msg_valid <= 1'b0;
      if (frame_err) begin
        // A corrupted byte breaks the message but not the running status.
        have_d1 <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data[7:4] == 4'hF) begin
          // System common / SysEx cancels running status; real-time is ignored.
          if (!byte_data[3]) begin
            run_status <= '0;
            have_d1    <= 1'b0;
          end
        end else if (byte_data[7]) begin
          run_status <= byte_data;
          have_d1    <= 1'b0;
        end else if (run_status[7]) begin
          if (need_one || have_d1) begin
            have_d1 <= 1'b0;
            if (chan_ok) begin
              msg_valid  <= 1'b1;
              msg_status <= comp_status;
              msg_data1  <= comp_d1;
              msg_data2  <= comp_d2;
            end
          end else begin
            data1_q <= byte_data[6:0];
            have_d1 <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_receiver.sv
// Directed bench for midi_msg_receiver. Two instances share the serial line:
// dut_a converts note-on velocity 0 to note-off, dut_b does not. Expected
// strobes are queued when stimulus is sent and compared as the DUTs emit them.
module tb_midi_msg_receiver;

  localparam int CPB = 128;

  typedef struct packed {
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
  } msg_t;

  logic       clck = 1'b0;
  logic       rst;
  logic       midi_data;
  logic [3:0] channel;
  logic       omni;

  logic       a_byte_valid, a_msg_valid, a_rt_valid, a_frame_err;
  logic [7:0] a_byte_data, a_msg_status, a_rt_byte;
  logic [6:0] a_msg_data1, a_msg_data2;
  logic       b_byte_valid, b_msg_valid, b_rt_valid, b_frame_err;
  logic [7:0] b_byte_data, b_msg_status, b_rt_byte;
  logic [6:0] b_msg_data1, b_msg_data2;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_byte_a[$], exp_byte_b[$];
  logic [7:0] exp_rt_a[$],   exp_rt_b[$];
  msg_t       exp_msg_a[$],  exp_msg_b[$];
  int         exp_ferr_a = 0, exp_ferr_b = 0;

  always #5 clck = ~clck;

  midi_msg_receiver #(.CLKS_PER_BIT(CPB), .NOTE_ON_ZERO_AS_OFF(1'b1)) dut_a (
    .clck(clck), .rst(rst), .midi_data(midi_data), .channel(channel), .omni(omni),
    .byte_valid(a_byte_valid), .byte_data(a_byte_data), .msg_valid(a_msg_valid),
    .msg_status(a_msg_status), .msg_data1(a_msg_data1), .msg_data2(a_msg_data2),
    .rt_valid(a_rt_valid), .rt_byte(a_rt_byte), .frame_err(a_frame_err)
  );

  midi_msg_receiver #(.CLKS_PER_BIT(CPB), .NOTE_ON_ZERO_AS_OFF(1'b0)) dut_b (
    .clck(clck), .rst(rst), .midi_data(midi_data), .channel(channel), .omni(omni),
    .byte_valid(b_byte_valid), .byte_data(b_byte_data), .msg_valid(b_msg_valid),
    .msg_status(b_msg_status), .msg_data1(b_msg_data1), .msg_data2(b_msg_data2),
    .rt_valid(b_rt_valid), .rt_byte(b_rt_byte), .frame_err(b_frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitors (sample on falling edge) ------------
  always @(negedge clck) begin : mon_a
    msg_t m;
    if (a_byte_valid) begin
      check("a_byte_expected", exp_byte_a.size() != 0, 1);
      if (exp_byte_a.size() != 0) check("a_byte_data", a_byte_data, exp_byte_a.pop_front());
    end
    if (a_rt_valid) begin
      check("a_rt_expected", exp_rt_a.size() != 0, 1);
      if (exp_rt_a.size() != 0) check("a_rt_byte", a_rt_byte, exp_rt_a.pop_front());
    end
    if (a_frame_err) begin
      check("a_ferr_expected", exp_ferr_a > 0, 1);
      exp_ferr_a--;
    end
    if (a_msg_valid) begin
      check("a_msg_expected", exp_msg_a.size() != 0, 1);
      if (exp_msg_a.size() != 0) begin
        m = exp_msg_a.pop_front();
        check("a_msg_status", a_msg_status, m.st);
        check("a_msg_data1", a_msg_data1, m.d1);
        check("a_msg_data2", a_msg_data2, m.d2);
      end
    end
  end

  always @(negedge clck) begin : mon_b
    msg_t m;
    if (b_byte_valid) begin
      check("b_byte_expected", exp_byte_b.size() != 0, 1);
      if (exp_byte_b.size() != 0) check("b_byte_data", b_byte_data, exp_byte_b.pop_front());
    end
    if (b_rt_valid) begin
      check("b_rt_expected", exp_rt_b.size() != 0, 1);
      if (exp_rt_b.size() != 0) check("b_rt_byte", b_rt_byte, exp_rt_b.pop_front());
    end
    if (b_frame_err) begin
      check("b_ferr_expected", exp_ferr_b > 0, 1);
      exp_ferr_b--;
    end
    if (b_msg_valid) begin
      check("b_msg_expected", exp_msg_b.size() != 0, 1);
      if (exp_msg_b.size() != 0) begin
        m = exp_msg_b.pop_front();
        check("b_msg_status", b_msg_status, m.st);
        check("b_msg_data1", b_msg_data1, m.d1);
        check("b_msg_data2", b_msg_data2, m.d2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic drive_bit(input logic v);
    midi_data = v;
    repeat (CPB) @(negedge clck);
  endtask

  // Sends one frame followed by two idle bit times.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      exp_byte_a.push_back(b);
      exp_byte_b.push_back(b);
      if (b >= 8'hF8) begin
        exp_rt_a.push_back(b);
        exp_rt_b.push_back(b);
      end
    end else begin
      exp_ferr_a++;
      exp_ferr_b++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic expect_msg(input logic [7:0] st_a, input logic [7:0] st_b,
                            input logic [6:0] d1, input logic [6:0] d2);
    exp_msg_a.push_back('{st: st_a, d1: d1, d2: d2});
    exp_msg_b.push_back('{st: st_b, d1: d1, d2: d2});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_byte_data"},  a_byte_data,  8'h00);
    check({tag, "_msg_status"}, a_msg_status, 8'h00);
    check({tag, "_msg_data1"},  a_msg_data1,  7'h00);
    check({tag, "_msg_data2"},  a_msg_data2,  7'h00);
    check({tag, "_rt_byte"},    a_rt_byte,    8'h00);
    check({tag, "_strobes"}, {a_byte_valid, a_msg_valid, a_rt_valid, a_frame_err}, 4'b0000);
    check({tag, "_b_msg_status"}, b_msg_status, 8'h00);
  endtask

  // ---------------- directed sequence ----------------------------------------
  initial begin
    rst       = 1'b1;
    midi_data = 1'b1;
    channel   = 4'd0;
    omni      = 1'b1;
    repeat (4) @(negedge clck);
    check_cleared("reset");
    rst = 1'b0;
    repeat (10) @(negedge clck);

    // Plain note-on.
    expect_msg(8'h90, 8'h90, 7'h3C, 7'h64);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);

    // Running status with velocity-0 note-on.
    expect_msg(8'h90, 8'h90, 7'h3C, 7'h64);
    expect_msg(8'h80, 8'h90, 7'h40, 7'h00);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);

    // Real-time byte inside a message, then a two-byte program change.
    expect_msg(8'h90, 8'h90, 7'h3C, 7'h64);
    send_byte(8'h90, 1'b1); send_byte(8'hF8, 1'b1);
    send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    expect_msg(8'hC5, 8'hC5, 7'h07, 7'h00);
    send_byte(8'hC5, 1'b1); send_byte(8'h07, 1'b1);

    // Channel filter: channel 1 message rejected, then accepted with omni.
    channel = 4'd0;
    omni    = 1'b0;
    send_byte(8'h91, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    omni = 1'b1;
    expect_msg(8'h91, 8'h91, 7'h3C, 7'h64);
    send_byte(8'h91, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);

    // Short low glitch must be rejected as a false start.
    midi_data = 1'b0;
    repeat (CPB / 4) @(negedge clck);
    midi_data = 1'b1;
    repeat (3 * CPB) @(negedge clck);

    // Framing error after a data byte drops the partial message; the
    // following 0x3C 0x64 completes under the retained 0x90 status.
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
    send_byte(8'h55, 1'b0);
    expect_msg(8'h90, 8'h90, 7'h3C, 7'h64);
    send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);

    // Reset midway through the second data byte of a note-on.
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
    drive_bit(1'b0);          // start
    drive_bit(1'b0);          // bit 0 of 0x64
    drive_bit(1'b0);          // bit 1
    midi_data = 1'b1;         // bit 2, line stays high from here
    repeat (CPB / 2) @(negedge clck);
    rst = 1'b1;
    @(negedge clck);
    rst = 1'b0;
    check_cleared("midreset");
    repeat (12 * CPB) @(negedge clck);

    expect_msg(8'h80, 8'h80, 7'h3C, 7'h00);
    send_byte(8'h80, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);
    repeat (2 * CPB) @(negedge clck);

    // Everything queued must have been delivered.
    check("a_bytes_left", exp_byte_a.size(), 0);
    check("b_bytes_left", exp_byte_b.size(), 0);
    check("a_rt_left",    exp_rt_a.size(),   0);
    check("b_rt_left",    exp_rt_b.size(),   0);
    check("a_msgs_left",  exp_msg_a.size(),  0);
    check("b_msgs_left",  exp_msg_b.size(),  0);
    check("a_ferr_left",  exp_ferr_a,        0);
    check("b_ferr_left",  exp_ferr_b,        0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
